// File: rtl/lookup_pkg.sv
// Shared definitions for the lookup pipeline localbus master: bus widths,
// engine-select field location and the localbus cycle state encoding.
package lookup_pkg;

    localparam int LB_ADDR_W      = 32;
    localparam int LB_DATA_W      = 32;
    localparam int ENGINE_SEL_MSB = 18;
    localparam int ENGINE_SEL_LSB = 16;
    localparam int TO_CNT_W       = 16;
    localparam int GAP_CNT_W      = 4;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_ALE_ENC  = 2'd1;
    localparam logic [1:0] ST_CS_ENC   = 2'd2;
    localparam logic [1:0] ST_REL_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ALE  = ST_ALE_ENC,
        ST_CS   = ST_CS_ENC,
        ST_REL  = ST_REL_ENC
    } lb_state_e;

endpackage

// File: rtl/lookup_lb_master_if.sv
// Requester handshakes, responses and the localbus pins of lookup_lb_master.
// master = the arbiter side, slave = requesters plus the localbus device.
interface lookup_lb_master_if;
    import lookup_pkg::*;

    logic                 req0_valid;
    logic                 req0_ready;
    logic                 req0_rd_wr;
    logic [LB_ADDR_W-1:0] req0_addr;
    logic [LB_DATA_W-1:0] req0_wdata;
    logic                 req1_valid;
    logic                 req1_ready;
    logic                 req1_rd_wr;
    logic [LB_ADDR_W-1:0] req1_addr;
    logic [LB_DATA_W-1:0] req1_wdata;

    logic                 rsp0_valid;
    logic [LB_DATA_W-1:0] rsp0_rdata;
    logic                 rsp0_err;
    logic                 rsp1_valid;
    logic [LB_DATA_W-1:0] rsp1_rdata;
    logic                 rsp1_err;

    logic                 lb_cs_n;
    logic                 lb_rd_wr;
    logic                 lb_ale;
    logic [LB_DATA_W-1:0] lb_data;
    logic                 lb_ack_n;
    logic [LB_DATA_W-1:0] lb_data_in;

    modport master (
        input  req0_valid, req0_rd_wr, req0_addr, req0_wdata,
        input  req1_valid, req1_rd_wr, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp0_err,
        output rsp1_valid, rsp1_rdata, rsp1_err,
        output lb_cs_n, lb_rd_wr, lb_ale, lb_data,
        input  lb_ack_n, lb_data_in
    );

    modport slave (
        output req0_valid, req0_rd_wr, req0_addr, req0_wdata,
        output req1_valid, req1_rd_wr, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp0_err,
        input  rsp1_valid, rsp1_rdata, rsp1_err,
        input  lb_cs_n, lb_rd_wr, lb_ale, lb_data,
        output lb_ack_n, lb_data_in
    );

endinterface

// File: rtl/lb_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the side named by rr_ptr (0 = req0, 1 = req1).
module lb_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic       gnt_any,
    output logic       gnt_sel
);

    always_comb begin
        gnt_any = |valid;
        if (&valid) begin
            gnt_sel = rr_ptr;
        end else begin
            gnt_sel = valid[1];
        end
    end

endmodule

// File: rtl/lookup_lb_master.sv
// Localbus master for the lookup configuration port: arbitrates the host
// bridge (req0) and the rule-update engine (req1), then runs one ALE/CS/ACK cycle.
module lookup_lb_master
    import lookup_pkg::*;
#(
    parameter int TO_CYCLES = 255,
    parameter int IDLE_GAP  = 1
) (
    input logic                clk,
    input logic                reset,
    lookup_lb_master_if.master bus
);

    localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(TO_CYCLES - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(IDLE_GAP);

    lb_state_e             state;
    lb_state_e             state_next;
    logic                  grant_pend;
    logic                  gnt_any;
    logic                  gnt_sel;
    logic                  rr_ptr;
    logic                  gnt_q;
    logic                  rd_wr_q;
    logic [LB_ADDR_W-1:0]  addr_q;
    logic [LB_DATA_W-1:0]  wdata_q;
    logic [LB_DATA_W-1:0]  rdata_q;
    logic                  err_q;
    logic [TO_CNT_W-1:0]   to_cnt;
    logic [GAP_CNT_W-1:0]  gap_cnt;

    logic                  grant_now;
    logic                  to_hit;
    logic                  cs_ack;
    logic                  cs_to;
    logic                  rel_done;
    logic                  rel_to;
    logic                  rsp_err;

    lb_rr_arb2 u_arb (
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .rr_ptr  (rr_ptr),
        .gnt_any (gnt_any),
        .gnt_sel (gnt_sel)
    );

    // The grant cycle only pulses ready; ALE follows one cycle later, so IDLE
    // holds for one extra cycle with grant_pend set before moving on.
    always_comb begin
        state_next = state;
        grant_now  = 1'b0;
        to_hit     = (to_cnt == TO_LAST);
        cs_ack     = 1'b0;
        cs_to      = 1'b0;
        rel_done   = 1'b0;
        rel_to     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_pend) begin
                    state_next = ST_ALE;
                end else if (gnt_any && (gap_cnt == '0)) begin
                    grant_now = 1'b1;
                end
            end
            ST_ALE: begin
                state_next = ST_CS;
            end
            ST_CS: begin
                if (!bus.lb_ack_n) begin
                    cs_ack     = 1'b1;
                    state_next = ST_REL;
                end else if (to_hit) begin
                    cs_to      = 1'b1;
                    state_next = ST_REL;
                end
            end
            ST_REL: begin
                if (bus.lb_ack_n) begin
                    rel_done = 1'b1;
                end else if (to_hit) begin
                    rel_to   = 1'b1;
                    rel_done = 1'b1;
                end
                if (rel_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        rsp_err = err_q | rel_to;
    end

    // Bus pins are registered from state_next so the visible phase always
    // matches the state the FSM is in during that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            grant_pend     <= 1'b0;
            rr_ptr         <= 1'b0;
            gnt_q          <= 1'b0;
            rd_wr_q        <= 1'b1;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            to_cnt         <= '0;
            gap_cnt        <= '0;
            bus.req0_ready <= 1'b0;
            bus.req1_ready <= 1'b0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp0_rdata <= '0;
            bus.rsp0_err   <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp1_rdata <= '0;
            bus.rsp1_err   <= 1'b0;
            bus.lb_cs_n    <= 1'b1;
            bus.lb_ale     <= 1'b0;
            bus.lb_rd_wr   <= 1'b1;
            bus.lb_data    <= '0;
        end else begin
            state      <= state_next;
            grant_pend <= grant_now;

            if (grant_now) begin
                gnt_q   <= gnt_sel;
                rd_wr_q <= gnt_sel ? bus.req1_rd_wr : bus.req0_rd_wr;
                addr_q  <= gnt_sel ? bus.req1_addr  : bus.req0_addr;
                wdata_q <= gnt_sel ? bus.req1_wdata : bus.req0_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (cs_ack && rd_wr_q) begin
                rdata_q <= bus.lb_data_in;
            end
            if (cs_to || rel_to) begin
                err_q <= 1'b1;
            end

            if (state_next != state) begin
                to_cnt <= '0;
            end else if ((state == ST_CS) || (state == ST_REL)) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (rel_done) begin
                gap_cnt <= GAP_LOAD;
                rr_ptr  <= ~gnt_q;
            end else if ((state == ST_IDLE) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            bus.req0_ready <= grant_now & ~gnt_sel;
            bus.req1_ready <= grant_now &  gnt_sel;
            bus.rsp0_valid <= rel_done & ~gnt_q;
            bus.rsp1_valid <= rel_done &  gnt_q;
            bus.rsp0_err   <= rel_done & ~gnt_q & rsp_err;
            bus.rsp1_err   <= rel_done &  gnt_q & rsp_err;
            bus.rsp0_rdata <= (rel_done && !gnt_q && !rsp_err) ? rdata_q : '0;
            bus.rsp1_rdata <= (rel_done &&  gnt_q && !rsp_err) ? rdata_q : '0;

            bus.lb_ale   <= (state_next == ST_ALE);
            bus.lb_cs_n  <= (state_next != ST_CS);
            bus.lb_rd_wr <= ((state_next == ST_ALE) || (state_next == ST_CS)) ? rd_wr_q : 1'b1;
            if (state_next == ST_ALE) begin
                bus.lb_data <= addr_q;
            end else if ((state_next == ST_CS) && !rd_wr_q) begin
                bus.lb_data <= wdata_q;
            end else begin
                bus.lb_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lookup_lb_master.sv
// Bench for lookup_lb_master: a scripted localbus slave plus a timing and
// round-robin reference model derived from the cycle latency rules.
module tb_lookup_lb_master;

    localparam int TO_CYCLES = 8;
    localparam int IDLE_GAP  = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    int   n_checks = 0;
    int   n_fail   = 0;

    int          last_rsp    = -1000;
    bit          exp_rr      = 1'b0;
    int          slave_wait  = 0;
    int          slave_hold  = 0;
    logic [31:0] slave_rdata = '0;
    bit          spur        = 1'b0;

    lookup_lb_master_if bus();

    lookup_lb_master #(
        .TO_CYCLES (TO_CYCLES),
        .IDLE_GAP  (IDLE_GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Localbus device: acks after slave_wait CS cycles (-1 = never), then
    // keeps ack_n low for slave_hold cycles after cs_n rises.
    initial begin : slave_model
        int cs_count;
        int hold_left;
        cs_count  = 0;
        hold_left = 0;
        forever begin
            @(negedge clk);
            if (spur) begin
                bus.lb_ack_n = 1'b0;
                hold_left    = 0;
            end else if (!bus.lb_cs_n) begin
                if (slave_wait >= 0 && cs_count >= slave_wait) begin
                    bus.lb_ack_n   = 1'b0;
                    bus.lb_data_in = slave_rdata;
                end
                cs_count++;
                hold_left = slave_hold;
            end else begin
                cs_count = 0;
                if (!bus.lb_ack_n) begin
                    if (hold_left > 0) begin
                        hold_left--;
                    end else begin
                        bus.lb_ack_n   = 1'b1;
                        bus.lb_data_in = '0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, required < 50000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_req(input int side, input bit v, input bit rd,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (side == 0) begin
            bus.req0_valid = v;
            bus.req0_rd_wr = rd;
            bus.req0_addr  = addr;
            bus.req0_wdata = wdata;
        end else begin
            bus.req1_valid = v;
            bus.req1_rd_wr = rd;
            bus.req1_addr  = addr;
            bus.req1_wdata = wdata;
        end
    endtask

    // One isolated transaction from one requester, every phase checked.
    task automatic run_one(input string tag, input int side, input bit rd,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int wait_c, input int hold_c, input logic [31:0] srdata);
        int          start, exp_ready, exp_cs, exp_hold;
        int          ready_cyc, ale_cyc, rsp_cyc, cs_cycles, ale_pulses, ready_pulses;
        logic [31:0] ale_data, cs_data, got_rdata, exp_rdata;
        logic        cs_rd_wr, got_err;
        bit          exp_to, done, other_evt;
        slave_wait  = wait_c;
        slave_hold  = hold_c;
        slave_rdata = srdata;
        set_req(side, 1'b1, rd, addr, wdata);
        start     = cyc;
        exp_ready = ((last_rsp + IDLE_GAP > start) ? last_rsp + IDLE_GAP : start) + 1;
        exp_to    = (wait_c < 0) || (wait_c >= TO_CYCLES);
        exp_cs    = exp_to ? TO_CYCLES : wait_c + 1;
        exp_hold  = exp_to ? 0 : hold_c;
        exp_rdata = (rd && !exp_to) ? srdata : 32'h0;
        ready_cyc = -1; ale_cyc = -1; rsp_cyc = -1;
        cs_cycles = 0; ale_pulses = 0; ready_pulses = 0;
        ale_data = 'x; cs_data = 'x; cs_rd_wr = 1'bx; got_rdata = 'x; got_err = 1'bx;
        done = 1'b0; other_evt = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (side == 0 ? bus.req0_ready : bus.req1_ready) begin
                ready_pulses++;
                if (ready_cyc < 0) ready_cyc = cyc;
                set_req(side, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (side == 0 ? (bus.req1_ready | bus.rsp1_valid) : (bus.req0_ready | bus.rsp0_valid))
                other_evt = 1'b1;
            if (bus.lb_ale) begin
                ale_pulses++;
                ale_cyc  = cyc;
                ale_data = bus.lb_data;
            end
            if (!bus.lb_cs_n) begin
                if (cs_cycles == 0) begin
                    cs_data  = bus.lb_data;
                    cs_rd_wr = bus.lb_rd_wr;
                end
                cs_cycles++;
            end
            if (side == 0 ? bus.rsp0_valid : bus.rsp1_valid) begin
                rsp_cyc   = cyc;
                got_rdata = (side == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
                got_err   = (side == 0) ? bus.rsp0_err : bus.rsp1_err;
                done      = 1'b1;
            end
        end
        set_req(side, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL %s rsp_seen: got no response, required one within 80 cycles", tag);
        end
        n_checks++;
        if (ready_cyc !== exp_ready) begin
            n_fail++;
            $display("[TB] FAIL %s ready_cycle: got %0d, required %0d", tag, ready_cyc, exp_ready);
        end
        n_checks++;
        if (ready_pulses !== 1 || ale_pulses !== 1) begin
            n_fail++;
            $display("[TB] FAIL %s pulse_count: got ready=%0d ale=%0d, required 1/1", tag, ready_pulses, ale_pulses);
        end
        n_checks++;
        if (ale_cyc !== ready_cyc + 1 || ale_data !== addr) begin
            n_fail++;
            $display("[TB] FAIL %s ale_phase: got cyc=%0d data=%h, required cyc=%0d data=%h",
                     tag, ale_cyc, ale_data, ready_cyc + 1, addr);
        end
        n_checks++;
        if (cs_data !== (rd ? 32'h0 : wdata) || cs_rd_wr !== rd) begin
            n_fail++;
            $display("[TB] FAIL %s cs_drive: got data=%h rd_wr=%b, required data=%h rd_wr=%b",
                     tag, cs_data, cs_rd_wr, rd ? 32'h0 : wdata, rd);
        end
        n_checks++;
        if (cs_cycles !== exp_cs) begin
            n_fail++;
            $display("[TB] FAIL %s cs_length: got %0d, required %0d", tag, cs_cycles, exp_cs);
        end
        n_checks++;
        if (rsp_cyc !== ready_cyc + 3 + exp_cs + exp_hold) begin
            n_fail++;
            $display("[TB] FAIL %s rsp_cycle: got %0d, required %0d", tag, rsp_cyc, ready_cyc + 3 + exp_cs + exp_hold);
        end
        n_checks++;
        if (got_rdata !== exp_rdata || got_err !== exp_to) begin
            n_fail++;
            $display("[TB] FAIL %s rsp_payload: got rdata=%h err=%b, required rdata=%h err=%b",
                     tag, got_rdata, got_err, exp_rdata, exp_to);
        end
        n_checks++;
        if (other_evt) begin
            n_fail++;
            $display("[TB] FAIL %s other_side: got activity on the idle requester, required none", tag);
        end
        last_rsp = done ? rsp_cyc : cyc;
        exp_rr   = (side == 0);
    endtask

    task automatic test_reset();
        bus.req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.lb_cs_n !== 1'b1 || bus.lb_ale !== 1'b0 || bus.lb_rd_wr !== 1'b1 || bus.lb_data !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_bus: got cs_n=%b ale=%b rd_wr=%b data=%h, required 1/0/1/00000000",
                     bus.lb_cs_n, bus.lb_ale, bus.lb_rd_wr, bus.lb_data);
        end
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err} !== 6'b0 ||
            bus.rsp0_rdata !== 32'h0 || bus.rsp1_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_handshake: got ready=%b%b rsp=%b%b, required all zero",
                     bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid);
        end
        bus.req1_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        last_rsp = -1000;
        exp_rr   = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        run_one("write_zero_wait", 0, 1'b0, 32'h0002_0010, 32'hA5A5_0001, 0, 0, 32'h1234_5678);
    endtask

    task automatic test_read_wait();
        run_one("read_wait", 1, 1'b1, 32'h0003_0004, 32'h0, 3, 0, 32'hDEAD_BEEF);
    endtask

    // Both requesters keep a request pending every cycle; grants must alternate.
    task automatic test_round_robin(input string tag, input int n);
        int          grants, rsps, rdy0, rdy1, avail, exp_ready;
        int          q_side[$];
        logic [31:0] q_rdata[$];
        bit          cur_rd[2];
        logic [31:0] exp_rdata;
        int          exp_side;
        slave_hold = 0;
        grants = 0; rsps = 0; rdy0 = 0; rdy1 = 0;
        for (int s = 0; s < 2; s++) begin
            cur_rd[s] = 1'($urandom_range(0, 1));
            set_req(s, 1'b1, cur_rd[s], $urandom, $urandom);
        end
        avail = cyc;
        for (int i = 0; i < 400 && rsps < n; i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (s == 0 ? bus.req0_ready : bus.req1_ready) begin
                    if (s == 0) rdy0++; else rdy1++;
                    exp_ready = ((last_rsp + IDLE_GAP > avail) ? last_rsp + IDLE_GAP : avail) + 1;
                    n_checks++;
                    if (s !== int'(exp_rr) || cyc !== exp_ready) begin
                        n_fail++;
                        $display("[TB] FAIL %s grant: got side=%0d cyc=%0d, required side=%0d cyc=%0d",
                                 tag, s, cyc, exp_rr, exp_ready);
                    end
                    slave_wait  = $urandom_range(0, 2);
                    slave_rdata = $urandom;
                    q_side.push_back(s);
                    q_rdata.push_back(cur_rd[s] ? slave_rdata : 32'h0);
                    grants++;
                    if (grants < n) begin
                        cur_rd[s] = 1'($urandom_range(0, 1));
                        set_req(s, 1'b1, cur_rd[s], $urandom, $urandom);
                    end else begin
                        set_req(s, 1'b0, 1'b0, 32'h0, 32'h0);
                    end
                end
            end
            for (int s = 0; s < 2; s++) begin
                if (s == 0 ? bus.rsp0_valid : bus.rsp1_valid) begin
                    exp_side  = (q_side.size() > 0) ? q_side.pop_front() : -1;
                    exp_rdata = (q_rdata.size() > 0) ? q_rdata.pop_front() : 32'hx;
                    n_checks++;
                    if (s !== exp_side ||
                        (s == 0 ? bus.rsp0_rdata : bus.rsp1_rdata) !== exp_rdata ||
                        (s == 0 ? bus.rsp0_err : bus.rsp1_err) !== 1'b0) begin
                        n_fail++;
                        $display("[TB] FAIL %s response: got side=%0d rdata=%h, required side=%0d rdata=%h err=0",
                                 tag, s, (s == 0 ? bus.rsp0_rdata : bus.rsp1_rdata), exp_side, exp_rdata);
                    end
                    exp_rr   = (s == 0);
                    last_rsp = cyc;
                    avail    = cyc;
                    rsps++;
                end
            end
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (rsps !== n || rdy0 !== n / 2 || rdy1 !== n / 2) begin
            n_fail++;
            $display("[TB] FAIL %s totals: got rsps=%0d ready0=%0d ready1=%0d, required %0d/%0d/%0d",
                     tag, rsps, rdy0, rdy1, n, n / 2, n / 2);
        end
    endtask

    task automatic test_timeout();
        run_one("timeout", 0, 1'b1, 32'h0001_0100, 32'h0, -1, 0, 32'hFFFF_FFFF);
        run_one("after_timeout", 1, 1'b1, 32'h0000_0200, 32'h0, 1, 0, 32'h0BAD_F00D);
    endtask

    task automatic test_ack_hold();
        run_one("ack_hold", 1, 1'b0, 32'h0002_0300, 32'h5555_AAAA, 1, 5, 32'h0);
    endtask

    task automatic test_spurious_ack();
        int events;
        events = 0;
        spur = 1'b1;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            if (!bus.lb_cs_n || bus.lb_ale || bus.rsp0_valid || bus.rsp1_valid) events++;
        end
        n_checks++;
        if (bus.lb_ack_n !== 1'b0 || events !== 0) begin
            n_fail++;
            $display("[TB] FAIL spurious_ack: got ack_n=%b bus_events=%0d, required ack_n=0 events=0",
                     bus.lb_ack_n, events);
        end
        spur = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen_cs;
        int events;
        run_one("pre_reset", 0, 1'b0, 32'h0000_0040, 32'h0000_0001, 0, 0, 32'h0);
        slave_wait = -1;
        set_req(0, 1'b1, 1'b0, 32'h0003_0080, 32'hCAFE_0001);
        seen_cs = 1'b0;
        for (int i = 0; i < 20 && !seen_cs; i++) begin
            @(negedge clk);
            if (bus.req0_ready) set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (!bus.lb_cs_n) seen_cs = 1'b1;
        end
        n_checks++;
        if (!seen_cs) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_cs_entry: got no CS phase, required one within 20 cycles");
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.lb_cs_n !== 1'b1 || bus.lb_ale !== 1'b0 || bus.lb_data !== 32'h0 ||
            bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_release: got cs_n=%b ale=%b data=%h rsp=%b%b, required 1/0/0/00",
                     bus.lb_cs_n, bus.lb_ale, bus.lb_data, bus.rsp0_valid, bus.rsp1_valid);
        end
        reset = 1'b1;
        events = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp0_valid || bus.rsp1_valid || bus.lb_ale || !bus.lb_cs_n) events++;
        end
        n_checks++;
        if (events !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_quiet: got %0d bus/rsp events after abort, required 0", events);
        end
        last_rsp   = -1000;
        exp_rr     = 1'b0;
        slave_wait = 0;
        test_round_robin("rr_after_reset", 2);
    endtask

    task automatic test_random(input int n);
        int r;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r = $urandom_range(0, 9);
            run_one("random", $urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    (r == 9) ? -1 : r % 5, $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin : main
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.lb_ack_n   = 1'b1;
        bus.lb_data_in = '0;
        reset = 1'b0;
        $display("[TB] starting lookup_lb_master bench");
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_round_robin("round_robin", 4);
        test_timeout();
        test_ack_hold();
        test_spurious_ack();
        test_reset_mid();
        test_random(16);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
